// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Instruction-fetch controller. Owns the program counter, issues one
// instruction-memory request at a time (req/gnt, then rvalid), hands the
// fetched word to decode under stall backpressure, and applies redirects from
// execute. A redirect that arrives while a request is outstanding marks the
// pending response as stale (kill) so it is discarded when it returns.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : misaligned redirect targets load TRAP_VEC and pulse
//               misalign_err for one cycle.
//   undefined : redirect targets are word-aligned by clearing bits [1:0];
//               misalign_err is tied low.
//
// Parameters
//   RESET_PC       PC loaded on reset
//   TRAP_VEC       misalignment trap target (macro builds only)
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active low
//   redirect_valid execute requests a PC change this cycle
//   redirect_pc    redirect target
//   stall          decode cannot accept an instruction this cycle
//   imem_req       fetch request valid
//   imem_addr      fetch address (equals pc_out)
//   imem_gnt       memory accepts the request
//   imem_rvalid    response data valid
//   imem_rdata     response data
//   inst_valid     instruction presented to decode
//   inst_data      instruction word
//   inst_pc        address of inst_data
//   pc_out         current fetch PC
//   misalign_err   one-cycle misaligned-redirect pulse
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0100_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_out,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] target;

  // Address actually loaded into the PC for a redirect request.
  function automatic logic [31:0] redirect_target(input logic [31:0] req_pc);
`ifdef PC_MISALIGN_TRAP_EN
    return (req_pc[1:0] != 2'b00) ? TRAP_VEC : req_pc;
`else
    return {req_pc[31:2], 2'b00};
`endif
  endfunction

  assign target     = redirect_target(redirect_pc);
  assign imem_req   = (state == REQ);
  assign inst_valid = (state == DELIVER);
  assign imem_addr  = pc;
  assign pc_out     = pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      inst_data <= 32'h0;
      inst_pc   <= 32'h0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
`ifdef PC_MISALIGN_TRAP_EN
      // Every state except IDLE honours a redirect, so that is when a
      // misaligned target is reported.
      misalign_err <= redirect_valid && (state != IDLE) &&
                      (redirect_pc[1:0] != 2'b00);
`endif
      case (state)
        IDLE: state <= REQ;

        REQ: begin
          if (redirect_valid) begin
            pc <= target;
            // Granted request was for the old PC: its response is stale.
            if (imem_gnt) begin
              kill  <= 1'b1;
              state <= WAIT;
            end
          end else if (imem_gnt) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (imem_rvalid) begin
            if (kill || redirect_valid) begin
              kill  <= 1'b0;
              if (redirect_valid) pc <= target;
              state <= REQ;
            end else begin
              inst_data <= imem_rdata;
              inst_pc   <= pc;
              pc        <= pc + 32'd4;
              state     <= DELIVER;
            end
          end else if (redirect_valid) begin
            pc   <= target;
            kill <= 1'b1;
          end
        end

        DELIVER: begin
          // Redirect takes priority over stall and drops the held word.
          if (redirect_valid) begin
            pc    <= target;
            state <= REQ;
          end else if (!stall) begin
            state <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef PC_MISALIGN_TRAP_EN
  assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch controller that owns the program counter and sequences the fetch datapath. It issues one instruction-memory request at a time over a request/grant and response-valid handshake, delivers fetched words to decode with a stall backpressure signal, and applies branch/jump redirects from execute. It also discards responses made stale by a redirect. It sits between the execute stage (redirect source), instruction memory, and decode.

## Interface

- `RESET_PC`, 32'h01000000: PC loaded on reset.
- `TRAP_VEC`, 32'h01000100: misalignment trap target (used only with `PC_MISALIGN_TRAP_EN`).

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `redirect_valid` in 1: execute requests a PC change this cycle.
- `redirect_pc` in 32: redirect target.
- `stall` in 1: decode cannot accept an instruction this cycle.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; always equals `pc_out`.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response data valid.
- `imem_rdata` in 32: response data.
- `inst_valid` out 1: instruction presented to decode.
- `inst_data` out 32: instruction word.
- `inst_pc` out 32: address of `inst_data`.
- `pc_out` out 32: current fetch PC.
- `misalign_err` out 1: one-cycle misaligned-redirect pulse; tied 0 without the macro.

## Operation

- States are IDLE, REQ, WAIT and DELIVER. Internal flag `kill` marks a stale outstanding response.
- Reset (`rst`=0 at an edge) sets:
  - state = IDLE, pc = `RESET_PC`, kill = 0;
  - `inst_valid` = 0, `inst_data` = 0, `inst_pc` = 0, `misalign_err` = 0.
- IDLE: `imem_req` = 0. Unconditionally goes to REQ on the next edge.
- REQ: `imem_req` = 1.
  - `imem_gnt` only: go to WAIT.
  - `redirect_valid` only: pc <= target, stay in REQ.
  - Both: pc <= target, kill <= 1, go to WAIT.
- WAIT: `imem_req` = 0.
  - `redirect_valid` without `imem_rvalid`: pc <= target, kill <= 1, stay in WAIT.
  - `imem_rvalid` with kill = 1 or `redirect_valid`: drop the data, kill <= 0, apply any redirect, go to REQ.
  - `imem_rvalid` otherwise: `inst_data` <= `imem_rdata`, `inst_pc` <= pc, pc <= pc + 4, go to DELIVER.
- DELIVER: `inst_valid` = 1.
  - `redirect_valid`: drop the instruction, pc <= target, go to REQ. Redirect beats stall.
  - `stall` = 0: instruction consumed this cycle, go to REQ.
  - `stall` = 1: hold `inst_data` and `inst_pc` stable.
- `imem_rvalid` outside WAIT is ignored. This covers responses arriving after a mid-operation reset.
- pc + 4 wraps modulo 2^32. 32'hFFFFFFFC increments to 32'h00000000.
- `inst_valid` is a decode of state DELIVER; no other output is combinational on inputs.

## Timing

- First request is asserted 2 cycles after reset is released: the IDLE cycle, then REQ.
- Minimum throughput is 3 cycles per instruction: REQ with gnt, WAIT with rvalid, DELIVER with no stall.
- A redirect is visible on `pc_out` and `imem_addr` the cycle after `redirect_valid`.
- At most one request is outstanding. `imem_req` is never asserted in WAIT.

## Configuration

- `PC_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]` != 0 loads pc = `TRAP_VEC` instead of the target.
  - `misalign_err` is 1 for exactly the following cycle.
  - All other redirect rules are unchanged.
- `PC_MISALIGN_TRAP_EN` undefined:
  - Targets load with bits [1:0] forced to 0.
  - `misalign_err` is constant 0.

## Test plan

- Reset then release, with gnt=1 and rvalid one cycle after gnt: `imem_addr` = 01000000 in cycle 2, then `inst_valid` presents data at `inst_pc` = 01000000, then the next request is at 01000004.
- `stall`=1 for 4 DELIVER cycles: `inst_valid`, `inst_data` and `inst_pc` stay stable; no `imem_req` is asserted until `stall` falls.
- Redirect to 01000040 in WAIT, with rvalid returning 0xDEADBEEF 2 cycles later: the word is dropped, `inst_valid` stays 0, and the next request goes to 01000040.
- Redirect and gnt in the same REQ cycle, with the stale response then returned: the response is discarded and the following request goes to the redirect target.
- Redirect to 01000042, with the macro defined: pc = 01000100 and a 1-cycle `misalign_err`. Without the macro: pc = 01000040 and `misalign_err` = 0.
- Reset asserted while in WAIT, with rvalid arriving during IDLE: it is ignored, pc = 01000000, and `inst_valid` = 0.
